polar_sched: RTL and testbench

POLAR_SCHED -- requirements
Module: polar_sched

---
 rtl/polar_sched_pkg.sv | 23 ++
 rtl/polar_sched_if.sv | 31 +++
 rtl/polar_sched_arb.sv | 32 +++
 rtl/polar_sched.sv | 141 ++++++++++++++
 tb/tb_polar_sched.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/polar_sched_pkg.sv
// Shared types and constants for the polar (magnitude/phase) scheduler around a shared CORDIC.
package polar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // 22 CORDIC iterations plus pre-rotation stage and output register
  localparam int unsigned LAT_DEF = 24;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned IW_DEF  = 16;
  localparam int unsigned OW_DEF  = 16;
  localparam int unsigned PW_DEF  = 25;

  // Channel index width, never narrower than one bit
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/polar_sched_if.sv
// Sample request/grant bus and result strobe bus of polar_sched.
interface polar_sched_if
  import polar_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned IW  = IW_DEF,
  parameter int unsigned OW  = OW_DEF,
  parameter int unsigned PW  = PW_DEF
) ();
  localparam int unsigned CW = ch_w(NCH);

  logic [NCH-1:0]    s_valid;
  logic [NCH-1:0]    s_ready;
  logic [NCH*IW-1:0] s_x;
  logic [NCH*IW-1:0] s_y;

  logic [NCH-1:0]    m_valid;
  logic [CW-1:0]     m_ch;
  logic [OW-1:0]     m_mag;
  logic [PW-1:0]     m_phase;

  modport master (
    output s_valid, s_x, s_y,
    input  s_ready, m_valid, m_ch, m_mag, m_phase
  );

  modport slave (
    input  s_valid, s_x, s_y,
    output s_ready, m_valid, m_ch, m_mag, m_phase
  );
endinterface

// File: rtl/polar_sched_arb.sv
// Round-robin arbiter: searches from last grant + 1, returns one-hot grant and updated pointer.
module rr_arbiter
  import polar_pkg::*;
#(
  parameter int unsigned N  = NCH_DEF,
  parameter int unsigned CW = ch_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] ptr_nxt
);

  logic [CW-1:0] idx;
  logic          found;

  always_comb begin
    grant   = '0;
    ptr_nxt = last;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = CW'((32'(last) + i + 32'd1) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = idx;
      end
    end
  end

endmodule

// File: rtl/polar_sched.sv
// Time-multiplexes NCH I/Q streams onto one pipelined CORDIC and tags results back to channels.
// Optional POLAR_SCHED_STATS_EN adds o_cnt, per-channel retired-result counters.
module polar_sched
  import polar_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned IW  = IW_DEF,
  parameter int unsigned OW  = OW_DEF,
  parameter int unsigned PW  = PW_DEF,
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  polar_sched_if.slave         bus,
  output logic                 c_ce,
  output logic signed [IW-1:0] c_x,
  output logic signed [IW-1:0] c_y,
  output logic                 c_aux,
  input  logic [OW-1:0]        c_mag,
  input  logic [PW-1:0]        c_phase,
  input  logic                 c_aux_o,
  output logic                 o_idle,
  output logic                 o_err
`ifdef POLAR_SCHED_STATS_EN
  ,
  output logic [NCH*32-1:0]    o_cnt
`endif
);

  localparam int unsigned CW = ch_w(NCH);
  localparam int unsigned FW = $clog2(LAT + 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  ptr, ptr_nxt;
  logic [NCH-1:0] req, grant;
  logic           issue, retire;
  logic [CW-1:0]  issue_ch, ret_ch;
  logic [FW-1:0]  cnt, cnt_nxt;
  logic [CW:0]    tag [LAT];

  // Next state and request gating; grants only while running and out of reset
  always_comb begin
    state_nxt = state;
    req       = '0;
    unique case (state)
      ST_IDLE:  if (i_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!rst) req = bus.s_valid;
        if (!i_en) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_en)                state_nxt = ST_RUN;
        else if (cnt_nxt == '0)  state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      o_idle <= 1'b1;
    end else begin
      state  <= state_nxt;
      o_idle <= (state_nxt == ST_IDLE);
    end
  end

  rr_arbiter #(.N(NCH), .CW(CW)) u_arb (
    .req     (req),
    .last    (ptr),
    .grant   (grant),
    .ptr_nxt (ptr_nxt)
  );

  assign issue       = |grant;
  assign issue_ch    = ptr_nxt;
  assign bus.s_ready = grant;
  assign c_ce        = ~rst;
  assign c_aux       = issue;

  always_comb begin
    c_x = '0;
    c_y = '0;
    if (issue) begin
      c_x = bus.s_x[issue_ch*IW +: IW];
      c_y = bus.s_y[issue_ch*IW +: IW];
    end
  end

  // Tag line mirrors the CORDIC pipeline; its tail is the retiring entry
  assign retire = tag[LAT-1][CW];
  assign ret_ch = tag[LAT-1][CW-1:0];

  assign bus.m_valid = (retire && !rst) ? (NCH'(1) << ret_ch) : '0;
  assign bus.m_ch    = ret_ch;
  assign bus.m_mag   = c_mag;
  assign bus.m_phase = c_phase;

  always_comb begin
    unique case ({issue, retire})
      2'b10:   cnt_nxt = cnt + FW'(1);
      2'b01:   cnt_nxt = cnt - FW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= CW'(NCH - 1);
      cnt   <= '0;
      o_err <= 1'b0;
      for (int unsigned i = 0; i < LAT; i++) tag[i] <= '0;
    end else begin
      cnt    <= cnt_nxt;
      tag[0] <= {issue, issue_ch};
      for (int unsigned i = 1; i < LAT; i++) tag[i] <= tag[i-1];
      if (issue) ptr <= ptr_nxt;
      // A valid tag must meet a valid CORDIC result
      if (retire && !c_aux_o) o_err <= 1'b1;
    end
  end

`ifdef POLAR_SCHED_STATS_EN
  logic [31:0] cnt_ch [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) cnt_ch[i] <= '0;
    end else if (retire) begin
      cnt_ch[ret_ch] <= cnt_ch[ret_ch] + 32'd1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign o_cnt[g*32 +: 32] = cnt_ch[g];
  end
`endif

endmodule

// File: tb/tb_polar_sched.sv
// Scoreboard bench for polar_sched with a behavioural CORDIC model of latency LAT.
module tb_polar_sched;
  import polar_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned IW  = 16;
  localparam int unsigned OW  = 16;
  localparam int unsigned PW  = 25;
  localparam int unsigned LAT = LAT_DEF;
  localparam int unsigned CW  = ch_w(NCH);
  localparam real         K   = 1.6467602581;
  localparam real         PI  = 3.14159265358979;

  typedef struct {
    int unsigned   due;
    int unsigned   ch;
    logic [OW-1:0] mag;
    logic [PW-1:0] ph;
  } exp_t;

  logic clk = 1'b0;
  logic rst, i_en;
  logic                 c_ce, c_aux, c_aux_o;
  logic signed [IW-1:0] c_x, c_y;
  logic [OW-1:0]        c_mag;
  logic [PW-1:0]        c_phase;
`ifdef POLAR_SCHED_STATS_EN
  logic [NCH*32-1:0]    o_cnt;
`endif
  logic o_idle, o_err;

  polar_sched_if #(.NCH(NCH), .IW(IW), .OW(OW), .PW(PW)) bus ();

  polar_sched #(.NCH(NCH), .IW(IW), .OW(OW), .PW(PW), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_en),
    .bus     (bus),
    .c_ce    (c_ce),
    .c_x     (c_x),
    .c_y     (c_y),
    .c_aux   (c_aux),
    .c_mag   (c_mag),
    .c_phase (c_phase),
    .c_aux_o (c_aux_o),
    .o_idle  (o_idle),
    .o_err   (o_err)
`ifdef POLAR_SCHED_STATS_EN
    ,
    .o_cnt   (o_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OW-1:0] gmag(input logic signed [IW-1:0] x, input logic signed [IW-1:0] y);
    real rx, ry;
    rx = x;
    ry = y;
    return OW'($rtoi(K * $sqrt(rx * rx + ry * ry) + 0.5));
  endfunction

  function automatic logic [PW-1:0] gph(input logic signed [IW-1:0] x, input logic signed [IW-1:0] y);
    real rx, ry;
    rx = x;
    ry = y;
    return PW'($rtoi($atan2(ry, rx) * (2.0 ** (PW - 1)) / PI));
  endfunction

  // Behavioural CORDIC: LAT-deep pipeline frozen while c_ce is low
  logic          p_aux [LAT] = '{default: 1'b0};
  logic [OW-1:0] p_mag [LAT] = '{default: '0};
  logic [PW-1:0] p_ph  [LAT] = '{default: '0};
  logic          aux_kill = 1'b0;

  always @(posedge clk) begin
    if (c_ce) begin
      p_aux[0] <= c_aux;
      p_mag[0] <= gmag(c_x, c_y);
      p_ph[0]  <= gph(c_x, c_y);
      for (int i = 1; i < LAT; i++) begin
        p_aux[i] <= p_aux[i-1];
        p_mag[i] <= p_mag[i-1];
        p_ph[i]  <= p_ph[i-1];
      end
    end
  end

  assign c_aux_o = p_aux[LAT-1] & ~aux_kill;
  assign c_mag   = p_mag[LAT-1];
  assign c_phase = p_ph[LAT-1];

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic signed [IW-1:0] xs [NCH];
  logic signed [IW-1:0] ys [NCH];
  int unsigned rr_last = NCH - 1;

  task automatic pack(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) begin
      bus.s_x[k*IW +: IW] = xs[k];
      bus.s_y[k*IW +: IW] = ys[k];
    end
    bus.s_valid = v;
  endtask

  task automatic drive_rand(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) begin
      xs[k] = IW'(int'($urandom_range(0, 16383)) - 8192);
      ys[k] = IW'(int'($urandom_range(0, 16383)) - 8192);
    end
    pack(v);
  endtask

  task automatic push_exp(input int unsigned ch);
    exp_t e;
    e.due = cyc + LAT;
    e.ch  = ch;
    e.mag = gmag(xs[ch], ys[ch]);
    e.ph  = gph(xs[ch], ys[ch]);
    sb.push_back(e);
  endtask

  // Pops one expectation per result strobe and compares timing, channel and payload
  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.m_valid !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: cyc=%0d m_valid=%b m_ch=%0d, required no result", cyc, bus.m_valid, bus.m_ch);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.due || bus.m_ch !== CW'(e.ch) || bus.m_valid !== (NCH'(1) << e.ch) ||
              bus.m_mag !== e.mag || bus.m_phase !== e.ph) begin
            errors++;
            $display("FAIL sb_result: cyc=%0d valid=%b ch=%0d mag=%0d ph=%0d, required cyc=%0d ch=%0d mag=%0d ph=%0d",
                     cyc, bus.m_valid, bus.m_ch, bus.m_mag, bus.m_phase, e.due, e.ch, e.mag, e.ph);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_en = 1'b1;
    drive_rand('1);
    @(negedge clk);
    #1;
    checks++;
    if (bus.s_ready !== '0 || c_ce !== 1'b0 || c_aux !== 1'b0 || bus.m_valid !== '0 || c_x !== '0) begin
      errors++;
      $display("FAIL reset_outputs: s_ready=%b c_ce=%b c_aux=%b m_valid=%b c_x=%0d, required all 0",
               bus.s_ready, c_ce, c_aux, bus.m_valid, c_x);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_idle !== 1'b1 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: o_idle=%b o_err=%b, required 1 0", o_idle, o_err);
    end
    @(negedge clk);
    rst = 1'b0;
    i_en = 1'b0;
    pack('0);
    #1;
    checks++;
    if (c_ce !== 1'b1 || bus.s_ready !== '0 || o_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: c_ce=%b s_ready=%b o_idle=%b, required 1 0000 1", c_ce, bus.s_ready, o_idle);
    end
  endtask

  task automatic test_stream_all();
    int unsigned e;
    int strobes;
    @(negedge clk);
    i_en = 1'b1;
    drive_rand('1);
    #1;
    checks++;
    if (bus.s_ready !== '0) begin
      errors++;
      $display("FAIL idle_no_grant: s_ready=%b, required 0000", bus.s_ready);
    end
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 40) i_en = 1'b0;
      drive_rand('1);
      #1;
      e = (rr_last + 1) % NCH;
      rr_last = e;
      checks++;
      if (bus.s_ready !== (NCH'(1) << e) || c_x !== xs[e] || c_y !== ys[e] || c_aux !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant: k=%0d s_ready=%b c_x=%0d c_y=%0d c_aux=%b, required grant ch%0d x=%0d y=%0d aux=1",
                 k, bus.s_ready, c_x, c_y, c_aux, e, xs[e], ys[e]);
      end
      push_exp(e);
    end
    strobes = 0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      drive_rand('1);
      #1;
      if (bus.m_valid !== '0) strobes++;
      if (k == 1) begin
        checks++;
        if (bus.s_ready !== '0 || c_aux !== 1'b0 || c_x !== '0) begin
          errors++;
          $display("FAIL drain_no_grant: s_ready=%b c_aux=%b c_x=%0d, required 0000 0 0", bus.s_ready, c_aux, c_x);
        end
      end
      if (k == 24 || k == 25) begin
        checks++;
        if (o_idle !== (k == 25)) begin
          errors++;
          $display("FAIL drain_idle: k=%0d o_idle=%b, required %b", k, o_idle, (k == 25));
        end
      end
    end
    checks++;
    if (strobes != 24) begin
      errors++;
      $display("FAIL drain_strobes: got %0d, required 24", strobes);
    end
    pack('0);
  endtask

  task automatic test_single_ch2();
    int unsigned t;
    @(negedge clk);
    i_en = 1'b1;
    pack('0);
    @(negedge clk);
    drive_rand('0);
    xs[2] = 16'sd16384;
    ys[2] = '0;
    pack(4'b0100);
    #1;
    checks++;
    if (bus.s_ready !== 4'b0100) begin
      errors++;
      $display("FAIL ch2_grant: s_ready=%b, required 0100", bus.s_ready);
    end
    push_exp(2);
    rr_last = 2;
    t = cyc;
    @(negedge clk);
    pack('0);
    i_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (cyc == t + LAT) begin
        checks++;
        if (bus.m_valid !== 4'b0100 || bus.m_ch !== CW'(2) || bus.m_phase !== '0 || bus.m_mag !== 16'd26981) begin
          errors++;
          $display("FAIL ch2_result: valid=%b ch=%0d mag=%0d ph=%0d, required 0100 2 26981 0",
                   bus.m_valid, bus.m_ch, bus.m_mag, bus.m_phase);
        end
      end
    end
    checks++;
    if (o_idle !== 1'b1) begin
      errors++;
      $display("FAIL ch2_idle: o_idle=%b, required 1", o_idle);
    end
  endtask

  task automatic test_rst_mid();
    int unsigned e;
    int bad;
    @(negedge clk);
    i_en = 1'b1;
    drive_rand('1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive_rand('1);
      #1;
      e = (rr_last + 1) % NCH;
      rr_last = e;
      push_exp(e);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    rr_last = NCH - 1;
    checks++;
    if (bus.s_ready !== '0 || c_aux !== 1'b0 || c_ce !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: s_ready=%b c_aux=%b c_ce=%b, required 0000 0 0", bus.s_ready, c_aux, c_ce);
    end
    @(negedge clk);
    rst = 1'b0;
    i_en = 1'b0;
    pack('0);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (bus.m_valid !== '0) bad++;
    end
    checks++;
    if (bad != 0 || o_err !== 1'b0 || o_idle !== 1'b1) begin
      errors++;
      $display("FAIL midrst_flush: strobes=%0d o_err=%b o_idle=%b, required 0 0 1", bad, o_err, o_idle);
    end
  endtask

  task automatic test_aux_err();
    int unsigned t;
    @(negedge clk);
    i_en = 1'b1;
    pack('0);
    @(negedge clk);
    drive_rand(4'b0010);
    #1;
    push_exp(1);
    rr_last = 1;
    t = cyc;
    @(negedge clk);
    pack('0);
    i_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      aux_kill = (cyc == t + LAT);
      #1;
      if (cyc == t + LAT || cyc == t + LAT + 1) begin
        checks++;
        if (o_err !== (cyc == t + LAT + 1)) begin
          errors++;
          $display("FAIL aux_err_set: cyc=%0d o_err=%b, required %b", cyc, o_err, (cyc == t + LAT + 1));
        end
      end
    end
    aux_kill = 1'b0;
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL aux_err_hold: o_err=%b, required 1", o_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_last = NCH - 1;
    #1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL aux_err_clear: o_err=%b, required 0", o_err);
    end
  endtask

`ifdef POLAR_SCHED_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    i_en = 1'b1;
    pack('0);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      drive_rand(4'b0010);
      #1;
      push_exp(1);
    end
    rr_last = 1;
    @(negedge clk);
    pack('0);
    i_en = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (o_cnt[63:32] !== 32'd1000 || o_cnt[31:0] !== '0 || o_cnt[127:64] !== '0) begin
      errors++;
      $display("FAIL stats_count: ch1=%0d ch0=%0d ch2=%0d ch3=%0d, required 1000 0 0 0",
               o_cnt[63:32], o_cnt[31:0], o_cnt[95:64], o_cnt[127:96]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    i_en = 1'b0;
    bus.s_valid = '0;
    bus.s_x = '0;
    bus.s_y = '0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_stream_all();
    test_single_ch2();
    test_rst_mid();
    test_aux_err();
`ifdef POLAR_SCHED_STATS_EN
    test_stats();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d results never seen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
